dffram_bank: RTL and testbench
==============================

Name: dffram_bank

Overview:
- Parametrised successor to the team's single-port DFF RAM.
- Simple dual-port memory: one write port and one read port, sharing one clock.
- Adds byte-enable writes, a selectable read-during-write mode, a registered read-valid strobe and a hardware clear sequencer that zeroes every word.
- Sits between the core load/store path and local scratch storage. BUSY gates all accesses during clearing.

Parameters:
- ADDRESS_LENGTH, 4, address width; DEPTH = 2**ADDRESS_LENGTH words, so every address is valid.
- DATA_LENGTH, 32, word width; must be a multiple of 8; NBYTES = DATA_LENGTH/8.
- RDW_MODE, 0, same-address read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new merged data).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- EN  input  1  bank enable.
- WE  input  1  write request.
- RE  input  1  read request.
- BE  input  NBYTES  byte enables for write; bit i covers Di[8i+7:8i].
- WA  input  ADDRESS_LENGTH  write address.
- RA  input  ADDRESS_LENGTH  read address.
- Di  input  DATA_LENGTH  write data.
- CLR  input  1  one-cycle request to zero the whole array.
- Do  output  DATA_LENGTH  registered read data.
- DoValid  output  1  high for exactly the cycle Do carries data from a read accepted on the previous edge.
- BUSY  output  1  clear sweep in progress; accesses ignored.

Behaviour:
- Reset (RST_N low, async): Do=0, DoValid=0, BUSY=1, FSM=CLEAR, clear counter=0. Array contents are not reset directly.
- After RST_N rises, the CLEAR sweep runs automatically.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each edge writes 0 to RAM[cnt], then cnt++.
  - After writing DEPTH-1, the FSM goes to IDLE and BUSY drops on that edge. BUSY is therefore high for exactly DEPTH cycles after reset release or after CLR is accepted.
  - During CLEAR, EN/WE/RE/BE/Di are ignored, Do=0 and DoValid=0.
  - CLR during CLEAR is ignored; the sweep does not restart.
- IDLE state, CLR=1:
  - Next state is CLEAR, cnt=0, BUSY=1 next cycle.
  - CLR has priority: any WE/RE in the same cycle is dropped, Do<=0, DoValid<=0.
- IDLE state, EN=0: no write; Do<=0, DoValid<=0 (same as previous generation).
- IDLE state, EN=1:
  - Write: if WE, for each i with BE[i]=1, RAM[WA] byte i <= Di byte i; bytes with BE[i]=0 are unchanged. WE with BE=0 is a legal no-op.
  - Read: if RE, Do<=RAM[RA] and DoValid<=1 on the same edge (1-cycle latency).
  - If RE=0, Do holds its value and DoValid<=0.
  - Reads and writes to different addresses in the same cycle are independent.
- Collision (EN=1, WE=1, RE=1, WA==RA):
  - RDW_MODE=0: Do = pre-write word.
  - RDW_MODE=1: Do = merged word (enabled bytes from Di, others old).
  - The array always ends with the merged word.
- Reset asserted mid-sweep: outputs return to reset values immediately; the sweep restarts from address 0 after release.
- Back-to-back reads every cycle give DoValid continuously high.

Test Plan (ADDRESS_LENGTH=4, DATA_LENGTH=32):
1. Release RST_N, hold RE=1, EN=1 → BUSY high exactly 16 cycles, DoValid=0 throughout. Then read addresses 0..15 → all Do=0x00000000.
2. In IDLE, write WA=3, Di=0xDEADBEEF, BE=4'b1111; then write WA=3, Di=0x11223344, BE=4'b0101; read RA=3 → Do=0xDE22BE44 one cycle after RE, DoValid pulse of 1 cycle.
3. RAM[5]=0xAAAAAAAA; same cycle WE=1, RE=1, WA=RA=5, Di=0x55555555, BE=4'b0011:
   - RDW_MODE=0 → Do=0xAAAAAAAA.
   - RDW_MODE=1 → Do=0xAAAA5555.
   - Both modes: a later read gives 0xAAAA5555.
4. EN=0 with WE=1, RE=1, WA=7, Di=0x12345678 → Do=0, DoValid=0. A later read of 7 returns the prior value, unchanged.
5. Fill all words with nonzero data, pulse CLR together with WE to WA=2 → BUSY for 16 cycles. A second CLR mid-sweep does not extend BUSY. All reads afterwards return 0, including address 2.
6. Assert RST_N low at sweep cycle 6 for 2 cycles → BUSY stays 1, Do=0. BUSY stays high for 16 full cycles after release.

Source files
------------

// File: rtl/dffram_bank.sv
// Simple dual-port DFF RAM bank: byte-enable writes, selectable read-during-write,
// registered read with valid strobe, and a clear sequencer that zeroes every word.
module dffram_bank #(
  parameter int ADDRESS_LENGTH = 4,
  parameter int DATA_LENGTH    = 32,
  parameter int RDW_MODE       = 0,
  localparam int NBYTES        = DATA_LENGTH / 8,
  localparam int DEPTH         = 2 ** ADDRESS_LENGTH
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      WE,
  input  logic                      RE,
  input  logic [NBYTES-1:0]         BE,
  input  logic [ADDRESS_LENGTH-1:0] WA,
  input  logic [ADDRESS_LENGTH-1:0] RA,
  input  logic [DATA_LENGTH-1:0]    Di,
  input  logic                      CLR,
  output logic [DATA_LENGTH-1:0]    Do,
  output logic                      DoValid,
  output logic                      BUSY,
  output logic                      dbg_state_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDRESS_LENGTH-1:0] cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0]    do_q, do_d;
  logic                      do_valid_q, do_valid_d;

  logic [DATA_LENGTH-1:0]    mem_q [DEPTH];
  logic                      mem_we;
  logic [ADDRESS_LENGTH-1:0] mem_wa;
  logic [DATA_LENGTH-1:0]    mem_wdata;

  logic [DATA_LENGTH-1:0]    be_mask;
  logic [DATA_LENGTH-1:0]    old_word;
  logic [DATA_LENGTH-1:0]    rd_word;
  logic [DATA_LENGTH-1:0]    merged_word;
  logic                      collide;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      be_mask[8*i +: 8] = {8{BE[i]}};
    end
  end

  // Writes are full-word read-modify-write so masked bytes keep their old value.
  assign old_word    = mem_q[WA];
  assign rd_word     = mem_q[RA];
  assign merged_word = (old_word & ~be_mask) | (Di & be_mask);
  assign collide     = WE && (WA == RA);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    do_d       = do_q;
    do_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = WA;
    mem_wdata  = merged_word;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = cnt_q;
        mem_wdata = '0;
        do_d      = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {ADDRESS_LENGTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          do_d    = '0;
        end else if (!EN) begin
          do_d = '0;
        end else begin
          mem_we = WE && (|BE);
          if (RE) begin
            do_d       = ((RDW_MODE != 0) && collide) ? merged_word : rd_word;
            do_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        do_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      do_q       <= '0;
      do_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      do_q       <= do_d;
      do_valid_q <= do_valid_d;
    end
  end

  // Array storage has no reset; the clear sweep after reset zeroes it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wdata;
    end
  end

  assign Do          = do_q;
  assign DoValid     = do_valid_q;
  assign BUSY        = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dffram_bank.sv
// Directed bench for dffram_bank; two instances cover READ_FIRST and WRITE_FIRST.
module tb_dffram_bank;

  logic        clk;
  logic        rst_n;
  logic        en, we, re, clr;
  logic [3:0]  be, wa, ra;
  logic [31:0] di;
  logic [31:0] do0, do1;
  logic        v0, v1, b0, b1, st0, st1;

  int checks   = 0;
  int failures = 0;

  dffram_bank #(.ADDRESS_LENGTH(4), .DATA_LENGTH(32), .RDW_MODE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .WE(we), .RE(re), .BE(be), .WA(wa), .RA(ra),
    .Di(di), .CLR(clr), .Do(do0), .DoValid(v0), .BUSY(b0), .dbg_state_o(st0)
  );

  dffram_bank #(.ADDRESS_LENGTH(4), .DATA_LENGTH(32), .RDW_MODE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .EN(en), .WE(we), .RE(re), .BE(be), .WA(wa), .RA(ra),
    .Di(di), .CLR(clr), .Do(do1), .DoValid(v1), .BUSY(b1), .dbg_state_o(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [31:0] exp_do, input logic exp_v);
    chk({tag, "_do0"}, do0, exp_do);
    chk({tag, "_do1"}, do1, exp_do);
    chk({tag, "_v0"}, {31'b0, v0}, {31'b0, exp_v});
    chk({tag, "_v1"}, {31'b0, v1}, {31'b0, exp_v});
  endtask

  // Counts edges until BUSY drops; optional CLR pulse before edge clr_at.
  task automatic sweep(input int clr_at, input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      clr = (i == clr_at);
      step();
      chk({tag, "_busy0"}, {31'b0, b0}, {31'b0, (i < 16)});
      chk({tag, "_busy1"}, {31'b0, b1}, {31'b0, (i < 16)});
      chk_both(tag, 32'h0, 1'b0);
      if (!b0 && !b1) begin
        n = i;
        break;
      end
    end
    clr = 1'b0;
    chk({tag, "_len"}, n, 16);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; re = 1'b0; wa = a; di = d; be = m;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    we = 1'b0; re = 1'b1; ra = a;
    step();
    chk_both(tag, exp, 1'b1);
    re = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; we = 1'b0; re = 1'b1; clr = 1'b0;
    be = 4'h0; wa = 4'h0; ra = 4'h0; di = 32'h0;
    step();
    step();
    chk("rst_busy0", {31'b0, b0}, 32'd1);
    chk("rst_busy1", {31'b0, b1}, 32'd1);
    chk_both("rst", 32'h0, 1'b0);

    // 1: release reset with RE held high
    rst_n = 1'b1;
    sweep(0, "init_sweep");
    for (int a = 0; a < 16; a++) begin
      ra = a[3:0];
      step();
      chk_both("init_rd", 32'h0, 1'b1);
    end
    re = 1'b0;

    // 2: byte-enable merge and single-cycle valid pulse
    wr(4'd3, 32'hDEADBEEF, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 32'hDE22BE44, "be_rd");
    step();
    chk_both("be_hold", 32'hDE22BE44, 1'b0);

    // 3: same-address read-during-write
    wr(4'd5, 32'hAAAAAAAA, 4'b1111);
    we = 1'b1; re = 1'b1; wa = 4'd5; ra = 4'd5; di = 32'h55555555; be = 4'b0011;
    step();
    chk("rdw_mode0", do0, 32'hAAAAAAAA);
    chk("rdw_mode1", do1, 32'hAAAA5555);
    chk("rdw_v0", {31'b0, v0}, 32'd1);
    chk("rdw_v1", {31'b0, v1}, 32'd1);
    we = 1'b0;
    step();
    chk_both("rdw_after", 32'hAAAA5555, 1'b1);
    re = 1'b0;

    // 3b: different addresses in one cycle are independent
    we = 1'b1; re = 1'b1; wa = 4'd6; ra = 4'd3; di = 32'h0F0F0F0F; be = 4'b1111;
    step();
    chk_both("indep_rd", 32'hDE22BE44, 1'b1);
    we = 1'b0;
    rd(4'd6, 32'h0F0F0F0F, "indep_wr");

    // WE with BE=0 is a no-op
    wr(4'd6, 32'hFFFFFFFF, 4'b0000);
    rd(4'd6, 32'h0F0F0F0F, "be_zero");

    // 4: bank disabled
    wr(4'd7, 32'h0BADF00D, 4'b1111);
    rd(4'd7, 32'h0BADF00D, "pre_en");
    en = 1'b0; we = 1'b1; re = 1'b1; wa = 4'd7; ra = 4'd7; di = 32'h12345678; be = 4'b1111;
    step();
    chk_both("en_off", 32'h0, 1'b0);
    en = 1'b1; we = 1'b0;
    rd(4'd7, 32'h0BADF00D, "en_off_keep");

    // 5: fill, then CLR with a colliding write; second CLR mid-sweep is ignored
    for (int a = 0; a < 16; a++) begin
      wr(a[3:0], 32'hA5000001 + a, 4'b1111);
    end
    rd(4'd2, 32'hA5000003, "fill_rd2");
    rd(4'd15, 32'hA5000010, "fill_rd15");
    clr = 1'b1; we = 1'b1; wa = 4'd2; di = 32'hFFFFFFFF; be = 4'b1111; re = 1'b1; ra = 4'd2;
    step();
    clr = 1'b0; we = 1'b0;
    chk("clr_busy0", {31'b0, b0}, 32'd1);
    chk("clr_busy1", {31'b0, b1}, 32'd1);
    chk_both("clr_edge", 32'h0, 1'b0);
    sweep(5, "clr_sweep");
    for (int a = 0; a < 16; a++) begin
      ra = a[3:0];
      step();
      chk_both("clr_rd", 32'h0, 1'b1);
    end
    re = 1'b0;

    // 6: reset mid-sweep restarts the sweep
    wr(4'd9, 32'hCAFEF00D, 4'b1111);
    rd(4'd9, 32'hCAFEF00D, "pre_rst_rd");
    rst_n = 1'b0;
    #1;
    chk_both("async_rst", 32'h0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy0", {31'b0, b0}, 32'd1);
    chk("mid_rst_busy1", {31'b0, b1}, 32'd1);
    chk_both("mid_rst", 32'h0, 1'b0);
    step();
    step();
    chk("mid_rst_hold0", {31'b0, b0}, 32'd1);
    chk_both("mid_rst_hold", 32'h0, 1'b0);
    rst_n = 1'b1;
    sweep(0, "rst_sweep");
    rd(4'd9, 32'h0, "post_rst_rd9");
    rd(4'd0, 32'h0, "post_rst_rd0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
